// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control unit: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with req/ready memory handshakes and sticky exceptions.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] instr,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        PCWrite,
  output logic        pcSrc,
  output logic        IRWrite,
  output logic        reg2loc,
  output logic        AluSrc,
  output logic        memtoReg,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic [3:0]  AluControl,
  output logic        exc,
  output logic [1:0]  exc_cause,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_EXC    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    C_RTYPE   = 2'd0,
    C_MEM     = 2'd1,
    C_BRANCH  = 2'd2,
    C_INVALID = 2'd3
  } opclass_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  localparam logic [1:0] CAUSE_OPCODE  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Counter is wide enough for any practical timeout; it saturates when disabled.
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic opclass_e classify(input logic [10:0] op);
    opclass_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: c = C_RTYPE;
      OP_LDUR, OP_STUR:               c = C_MEM;
      default:                        c = (op[10:3] == OP_CBZ_HI) ? C_BRANCH : C_INVALID;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_for(input logic [10:0] op);
    logic [3:0] a;
    case (op)
      OP_ADD:  a = 4'b0010;
      OP_SUB:  a = 4'b0110;
      OP_AND:  a = 4'b0000;
      OP_ORR:  a = 4'b0001;
      default: a = 4'b0010;
    endcase
    return a;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] op_q, op_d;
  logic        exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;
  logic        timeout_hit;
  logic [15:0] cnt_inc;

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state, bookkeeping and Moore/ready-qualified control decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    exc_d      = exc_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    PCWrite    = 1'b0;
    pcSrc      = 1'b0;
    IRWrite    = 1'b0;
    reg2loc    = 1'b0;
    AluSrc     = 1'b0;
    memtoReg   = 1'b0;
    regWrite   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    AluControl = 4'b0010;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        // Decode uses the live opcode; everything after uses the latched copy.
        op_d    = instr;
        reg2loc = (instr == OP_STUR) || (classify(instr) == C_BRANCH);
        case (classify(instr))
          C_RTYPE:  state_d = S_EXEC_R;
          C_MEM:    state_d = S_ADDR;
          C_BRANCH: state_d = S_BRANCH;
          default: begin
            state_d = S_EXC;
            cause_d = CAUSE_OPCODE;
          end
        endcase
      end
      S_EXEC_R: begin
        AluControl = alu_for(op_q);
        state_d    = S_WB;
      end
      S_ADDR: begin
        AluSrc  = 1'b1;
        state_d = (op_q == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        memRead  = 1'b1;
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEM_WR: begin
        dmem_req = 1'b1;
        memWrite = 1'b1;
        reg2loc  = 1'b1;
        if (dmem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        memtoReg = (op_q == OP_LDUR);
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        AluControl = 4'b0111;
        PCWrite    = zero;
        pcSrc      = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXC: begin
        state_d = S_EXC;
      end
      default: begin
        state_d = S_EXC;
        cause_d = CAUSE_OPCODE;
      end
    endcase

    // Every state change is an entry, so the wait counter always starts from zero.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end

    if (state_d == S_EXC) begin
      exc_d = 1'b1;
    end else begin
      exc_d = exc_q;
    end

    // A reset cycle must never commit PC/IR/register/memory side effects.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      regWrite = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
    end else begin
      imem_req = imem_req;
    end
  end

  // State, latched opcode, wait counter and sticky exception registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 16'd0;
      op_q    <= 11'd0;
      exc_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  assign exc       = exc_q;
  assign exc_cause = cause_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: cycle-by-cycle expected state, controls
// and exception flags for each instruction class, wait states, timeouts and reset.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] instr;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, PCWrite, pcSrc, IRWrite, reg2loc, AluSrc;
  logic        memtoReg, regWrite, memRead, memWrite;
  logic [3:0]  AluControl;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [3:0]  state_o;
  logic [14:0] ctrl_s;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, ADDR = 4'd3;
  localparam logic [3:0] MEM_RD = 4'd4, MEM_WR = 4'd5, WB = 4'd6, BRANCH = 4'd7, EXC = 4'd8;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .PCWrite(PCWrite), .pcSrc(pcSrc),
    .IRWrite(IRWrite), .reg2loc(reg2loc), .AluSrc(AluSrc), .memtoReg(memtoReg),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .AluControl(AluControl), .exc(exc), .exc_cause(exc_cause), .state_o(state_o)
  );

  assign ctrl_s = {imem_req, dmem_req, PCWrite, pcSrc, IRWrite, reg2loc, AluSrc,
                   memtoReg, regWrite, memRead, memWrite, AluControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic imr, input logic dmr, input logic pcw,
                                     input logic pcs, input logic irw, input logic r2l,
                                     input logic als, input logic m2r, input logic rw,
                                     input logic mr, input logic mw, input logic [3:0] alu);
    return {imr, dmr, pcw, pcs, irw, r2l, als, m2r, rw, mr, mw, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check the settled outputs, then advance one clock.
  task automatic cyc(input string tag, input logic rst, input logic ir, input logic dr,
                     input logic [10:0] ins, input logic z, input logic [3:0] est,
                     input logic [14:0] ectl, input logic eexc, input logic [1:0] ecause);
    reset      = rst;
    imem_ready = ir;
    dmem_ready = dr;
    instr      = ins;
    zero       = z;
    #1;
    check({tag, "/state"}, 32'(state_o), 32'(est));
    check({tag, "/ctrl"},  32'(ctrl_s),  32'(ectl));
    check({tag, "/exc"},   32'(exc),     32'(eexc));
    check({tag, "/cause"}, 32'(exc_cause), 32'(ecause));
    @(posedge clk);
    #1;
  endtask

  logic [14:0] idle, f_go, f_wait;
  logic [10:0] rops [4];
  logic [3:0]  ralu [4];

  initial begin
    idle   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    f_go   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    f_wait = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    rops[0] = OP_ADD; ralu[0] = 4'b0010;
    rops[1] = OP_SUB; ralu[1] = 4'b0110;
    rops[2] = OP_AND; ralu[2] = 4'b0000;
    rops[3] = OP_ORR; ralu[3] = 4'b0001;

    reset = 1'b1; instr = 11'd0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_hold", 1'b1, 1'b1, 1'b0, OP_ADD, 1'b0, FETCH, idle, 1'b0, 2'b00);

    // R-type: 4 cycles; opcode changes after DECODE must not affect AluControl.
    for (int i = 0; i < 4; i++) begin
      cyc("r_fetch",  1'b0, 1'b1, 1'b0, rops[i], 1'b0, FETCH,  f_go, 1'b0, 2'b00);
      cyc("r_decode", 1'b0, 1'b1, 1'b0, rops[i], 1'b0, DECODE, idle, 1'b0, 2'b00);
      cyc("r_exec",   1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, EXEC_R,
          mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ralu[i]), 1'b0, 2'b00);
      cyc("r_wb",     1'b0, 1'b1, 1'b0, OP_BAD,  1'b0, WB,
          mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    end

    // LDUR with three dmem wait cycles: 8 cycles total.
    cyc("ld_fetch",  1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("ld_decode", 1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, DECODE, idle, 1'b0, 2'b00);
    cyc("ld_addr",   1'b0, 1'b1, 1'b0, OP_BAD,  1'b0, ADDR,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc("ld_mem", 1'b0, 1'b1, (i == 3), OP_BAD, 1'b0, MEM_RD,
          mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010), 1'b0, 2'b00);
    end
    cyc("ld_wb",     1'b0, 1'b1, 1'b0, OP_BAD,  1'b0, WB,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);

    // STUR, zero-wait: 4 cycles.
    cyc("st_fetch",  1'b0, 1'b1, 1'b1, OP_STUR, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("st_decode", 1'b0, 1'b1, 1'b1, OP_STUR, 1'b0, DECODE,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("st_addr",   1'b0, 1'b1, 1'b1, OP_BAD,  1'b0, ADDR,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("st_mem",    1'b0, 1'b1, 1'b1, OP_BAD,  1'b0, MEM_WR,
        mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010), 1'b0, 2'b00);

    // CBZ taken then not taken: 3 cycles each.
    for (int z = 1; z >= 0; z--) begin
      cyc("cbz_fetch",  1'b0, 1'b1, 1'b0, OP_CBZ, z[0], FETCH, f_go, 1'b0, 2'b00);
      cyc("cbz_decode", 1'b0, 1'b1, 1'b0, OP_CBZ, z[0], DECODE,
          mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
      cyc("cbz_branch", 1'b0, 1'b1, 1'b0, OP_BAD, z[0], BRANCH,
          mk(1'b0, 1'b0, z[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111), 1'b0, 2'b00);
    end

    // imem ready on the 4th wait cycle still completes the fetch.
    for (int i = 0; i < 3; i++)
      cyc("to_wait", 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, FETCH, f_wait, 1'b0, 2'b00);
    cyc("to_late_go", 1'b0, 1'b1, 1'b0, OP_ADD, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("to_decode",  1'b0, 1'b1, 1'b0, OP_ADD, 1'b0, DECODE, idle, 1'b0, 2'b00);
    cyc("to_exec",    1'b0, 1'b1, 1'b0, OP_ADD, 1'b0, EXEC_R, idle, 1'b0, 2'b00);
    cyc("to_wb",      1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, WB,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);

    // imem never ready: exception 4 cycles after entering FETCH.
    for (int i = 0; i < 4; i++)
      cyc("ito_wait", 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, FETCH, f_wait, 1'b0, 2'b00);
    cyc("ito_exc",  1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, EXC, idle, 1'b1, 2'b10);
    cyc("ito_hold", 1'b0, 1'b1, 1'b1, OP_ADD, 1'b1, EXC, idle, 1'b1, 2'b10);
    cyc("ito_rst",  1'b1, 1'b1, 1'b1, OP_ADD, 1'b0, EXC, idle, 1'b1, 2'b10);

    // Invalid opcode.
    cyc("bad_fetch",  1'b0, 1'b1, 1'b0, OP_BAD, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("bad_decode", 1'b0, 1'b1, 1'b0, OP_BAD, 1'b0, DECODE, idle, 1'b0, 2'b00);
    cyc("bad_exc",    1'b0, 1'b1, 1'b1, OP_ADD, 1'b1, EXC,    idle, 1'b1, 2'b01);
    cyc("bad_hold",   1'b0, 1'b1, 1'b1, OP_ADD, 1'b1, EXC,    idle, 1'b1, 2'b01);
    cyc("bad_rst",    1'b1, 1'b1, 1'b0, OP_LDUR, 1'b0, EXC,   idle, 1'b1, 2'b01);

    // dmem never ready during a load.
    cyc("dto_fetch",  1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("dto_decode", 1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, DECODE, idle, 1'b0, 2'b00);
    cyc("dto_addr",   1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, ADDR,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    for (int i = 0; i < 4; i++)
      cyc("dto_wait", 1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, MEM_RD,
          mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("dto_exc",    1'b0, 1'b1, 1'b0, OP_LDUR, 1'b0, EXC, idle, 1'b1, 2'b10);
    cyc("dto_rst",    1'b1, 1'b1, 1'b0, OP_STUR, 1'b0, EXC, idle, 1'b1, 2'b10);

    // Reset in MEM_WR kills the write that cycle and returns to FETCH.
    cyc("rw_fetch",  1'b0, 1'b1, 1'b0, OP_STUR, 1'b0, FETCH,  f_go, 1'b0, 2'b00);
    cyc("rw_decode", 1'b0, 1'b1, 1'b0, OP_STUR, 1'b0, DECODE,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("rw_addr",   1'b0, 1'b1, 1'b0, OP_STUR, 1'b0, ADDR,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("rw_rst",    1'b1, 1'b1, 1'b1, OP_STUR, 1'b0, MEM_WR,
        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010), 1'b0, 2'b00);
    cyc("rw_after",  1'b0, 1'b0, 1'b0, OP_STUR, 1'b0, FETCH,  f_wait, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
